// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode-to-hazard-control bundle: decode-stage instruction fields and the
// EX branch outcome flow in; stall, flush, bubble, hold and busy controls
// plus the FSM state code flow out.
// Ports: master = decode side (drives id_*/branch_taken), slave = controller.
interface pipeline_hazard_ctrl_if #(
    parameter int N = 3
);
    logic         id_valid;
    logic [N-1:0] id_src;
    logic [N-1:0] id_dst;
    logic         id_uses_src;
    logic         id_uses_dst;
    logic         id_reg_write;
    logic         id_mem_read;
    logic         id_multi;
    logic         branch_taken;

    logic         pc_stall;
    logic         ifid_stall;
    logic         ifid_flush;
    logic         idex_bubble;
    logic         idex_hold;
    logic         ex_busy;
    logic [1:0]   state_o;

    modport master (
        output id_valid, id_src, id_dst, id_uses_src, id_uses_dst,
               id_reg_write, id_mem_read, id_multi, branch_taken,
        input  pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_hold,
               ex_busy, state_o
    );

    modport slave (
        input  id_valid, id_src, id_dst, id_uses_src, id_uses_dst,
               id_reg_write, id_mem_read, id_multi, branch_taken,
        output pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_hold,
               ex_busy, state_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, multi-cycle EX freeze.
// Latency: all controls are combinational from state/trackers/current inputs.
// Backpressure: pc_stall/ifid_stall freeze the front end; idex_hold freezes EX for MULCYC-1 cycles.
// Ports: clk, rst (sync, active-high); hz (slave modport) carries decode fields in, controls out.
module pipeline_hazard_ctrl #(
    parameter int N      = 3,
    parameter int MULCYC = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam logic [1:0] S_RUN     = 2'd0;
    localparam logic [1:0] S_LDSTALL = 2'd1;
    localparam logic [1:0] S_MULTI   = 2'd2;

    localparam int            CW       = 4;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MULCYC - 1);

    // Index of each tracker in trk_q.
    localparam int T_EX  = 0;
    localparam int T_MEM = 1;
    localparam int T_WB  = 2;

    typedef struct packed {
        logic         valid;
        logic [N-1:0] dst;
        logic         reg_write;
        logic         mem_read;
    } trk_t;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    trk_t          trk_q [0:2];
    trk_t          dec;

    logic lu;
    logic mul_go;

    logic pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_hold, ex_busy;

    assign dec.valid     = hz.id_valid;
    assign dec.dst       = hz.id_dst;
    assign dec.reg_write = hz.id_reg_write;
    assign dec.mem_read  = hz.id_mem_read;

    // A load sitting in EX whose destination the decode instruction reads.
    assign lu = hz.id_valid && trk_q[T_EX].valid && trk_q[T_EX].mem_read &&
                trk_q[T_EX].reg_write &&
                ((hz.id_uses_src && (hz.id_src == trk_q[T_EX].dst)) ||
                 (hz.id_uses_dst && (hz.id_dst == trk_q[T_EX].dst)));

    assign mul_go = hz.id_valid && hz.id_multi;

    // State register (with the multi-cycle counter).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RUN: begin
                if (hz.branch_taken) begin
                    state_d = S_RUN;
                end else if (lu) begin
                    state_d = S_LDSTALL;
                end else if (mul_go) begin
                    state_d = S_MULTI;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_LDSTALL: begin
                // The stalled instruction now advances; it may itself be a multi op.
                if (mul_go) begin
                    state_d = S_MULTI;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_MULTI: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // Output logic. In MULTI, branch_taken and lu are deliberately not looked at.
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        idex_hold   = 1'b0;
        ex_busy     = 1'b0;
        case (state_q)
            S_RUN: begin
                if (hz.branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (lu) begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (mul_go) begin
                    // Entry cycle counts toward the MULCYC cycles of occupancy.
                    ex_busy = 1'b1;
                end
            end
            S_MULTI: begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
                idex_hold  = 1'b1;
                ex_busy    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Stage trackers. While EX is held, nothing leaves it, so MEM sees a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                trk_q[i] <= '0;
            end
        end else begin
            trk_q[T_WB]  <= trk_q[T_MEM];
            trk_q[T_MEM] <= idex_hold ? '0 : trk_q[T_EX];
            if (idex_bubble) begin
                trk_q[T_EX] <= '0;
            end else if (!idex_hold) begin
                trk_q[T_EX] <= dec;
            end
        end
    end

    assign hz.pc_stall    = pc_stall;
    assign hz.ifid_stall  = ifid_stall;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.idex_bubble = idex_bubble;
    assign hz.idex_hold   = idex_hold;
    assign hz.ex_busy     = ex_busy;
    assign hz.state_o     = state_q;
endmodule
